coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
- Front end that feeds coins into the vending core.
- Turns raw coin switches into clean single-cycle nickel/dime/quarter pulses on the core's coin inputs.
- Synchronises and debounces each switch, detects each insertion, and holds pending coins in a small FIFO.
- Releases one coin at a time only when the core can safely absorb it, so no coin is lost during refund, vend or change-out.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required before the debounced level changes (≥1)
FIFO_DEPTH, 4, pending-coin queue entries (power of two, ≥2)
PRICE, 50, vend price in cents; dispatch is blocked while core_balance ≥ PRICE

Ports:
clk  in  1  core clock, the same slow clock that drives the vending core
reset  in  1  asynchronous, active-high
nickel_in  in  1  raw nickel switch, asynchronous
dime_in  in  1  raw dime switch, asynchronous
quarter_in  in  1  raw quarter switch, asynchronous
core_busy  in  1  core refunding flag; high means change-out is in progress
core_refund  in  1  refund request, the same signal the core receives
core_balance  in  7  core balance in cents
nickel  out  1  one-cycle coin pulse to the core
dime  out  1  one-cycle coin pulse to the core
quarter  out  1  one-cycle coin pulse to the core
pending  out  $clog2(FIFO_DEPTH)+1  number of queued coins
reject  out  3  one-cycle mask {quarter,dime,nickel} of insertions dropped this cycle
fifo_full  out  1  queue full

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Reset values:
  - synchroniser and debounced levels 0; debounce counters 0
  - FIFO empty; pending=0; fifo_full=0; reject=0
  - cooldown 0; coin outputs 0
- Synchroniser: 2-FF per raw input.
- Debounce, per input:
  - counter increments while the synchronised sample differs from the debounced level; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A switch held high through reset therefore registers one insertion after DEBOUNCE_CYCLES+2 cycles.
- Insertion: rising edge of a debounced level, 0→1 registered.
  - Falling edges are ignored.
  - One insertion per switch press.
- Enqueue, at most one per cycle:
  - Code is 2 bits: NICKEL=1, DIME=2, QUARTER=3.
  - Simultaneous insertions: enqueue the highest denomination; every other inserting bit is set in reject that cycle.
  - FIFO full with no pop this cycle: the insertion is dropped and its reject bit is set.
  - FIFO full with a pop in the same cycle: the enqueue succeeds and pending is unchanged.
- Dispatch: ready = !empty & !core_busy & !core_refund & (core_balance < PRICE) & !cooldown.
  - Outputs are combinational: the one-hot decode of the FIFO head when ready, otherwise 0.
  - On a clock edge where ready=1: pop the head and set cooldown for exactly one cycle.
  - Consecutive coins are therefore at least 2 cycles apart, so the core's balance has updated before the next ready evaluation.
- Latency: an insertion enqueued at edge N can appear on a coin output in the cycle after edge N at the earliest. An empty FIFO gives no bypass.
- Blocking: while ready=0 the head is held indefinitely. Coins are never discarded after enqueue.
  - This covers a refund in progress, a pending refund request, and a vend that is due.
- At most one coin output is high in any cycle.
- pending and fifo_full are registered and reflect the FIFO after each edge. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: immediate return to reset values. Queued coins are lost; the core is reset by the same signal.

Decomposition:
- Shared package coin_pkg holds:
  - typedef enum logic [1:0] coin_t {NONE, NICKEL, DIME, QUARTER}
  - localparam cent values 5, 10 and 25
- One sub-module, coin_debounce (2-FF sync + debounce counter + rising-edge detect), instantiated three times.
- FIFO and dispatch logic stay in coin_acceptor.

Test Plan:
- dime_in held high for 6 cycles after reset, DEBOUNCE_CYCLES=4 → exactly one dime pulse, first seen 7 cycles after dime_in rises; pending 0→1→0.
- dime_in toggled with bounces shorter than 4 cycles, then held high → exactly one dime pulse.
- Quarter and nickel debounced in the same cycle → one quarter pulse; reject=3'b001 for one cycle; pending=1.
- Five nickels inserted while core_busy=1, FIFO_DEPTH=4 → fifo_full=1, fifo_full stays 1 and reject=3'b001 when the fifth insertion is dropped, no outputs; release core_busy → four nickel pulses spaced exactly 2 cycles apart.
- core_balance=50 with two quarters queued → no outputs; core_balance→0 → first quarter pulse the next cycle, second quarter 2 cycles later.
- Reset asserted with 3 coins queued → outputs 0 and pending=0 immediately; no coin pulses after deassertion.

Source files
------------

// File: rtl/coin_pkg.sv
// coin_pkg: coin codes and denominations shared by the coin acceptor slice
package coin_pkg;
    typedef enum logic [1:0] {NONE, NICKEL, DIME, QUARTER} coin_t;
    localparam int NICKEL_CENTS  = 5;
    localparam int DIME_CENTS    = 10;
    localparam int QUARTER_CENTS = 25;
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-FF synchroniser, debounce counter and rising-edge pulse for one coin switch
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;
    // the sample that completes the run flips the level, so a held switch lands DEBOUNCE_CYCLES+2 edges in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_rise <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign o_rise = r_rise;
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces coin switches, queues insertions and releases one coin pulse at a time
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int PRICE           = 50
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          nickel_in,
    input  logic                          dime_in,
    input  logic                          quarter_in,
    input  logic                          core_busy,
    input  logic                          core_refund,
    input  logic [6:0]                    core_balance,
    output logic                          nickel,
    output logic                          dime,
    output logic                          quarter,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic [2:0]                    reject,
    output logic                          fifo_full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [2:0]  w_rise;
    logic [2:0]  w_win;
    coin_t       w_code;
    coin_t       w_head;
    logic        w_full;
    logic        w_ready;
    logic        w_push;
    coin_t       r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          r_cool;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (.clk(clk), .reset(reset), .i_raw(nickel_in),  .o_rise(w_rise[0]));
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime   (.clk(clk), .reset(reset), .i_raw(dime_in),    .o_rise(w_rise[1]));
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_quarter(.clk(clk), .reset(reset), .i_raw(quarter_in), .o_rise(w_rise[2]));

    // highest denomination wins a simultaneous insertion; the rest are rejected
    assign w_code  = w_rise[2] ? QUARTER : w_rise[1] ? DIME : w_rise[0] ? NICKEL : NONE;
    assign w_win   = w_rise[2] ? 3'b100 : w_rise[1] ? 3'b010 : (w_rise & 3'b001);
    assign w_full  = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_head  = r_mem[r_rd];
    assign w_ready = (r_count != '0) && !core_busy && !core_refund && (core_balance < 7'(PRICE)) && !r_cool;
    assign w_push  = (w_code != NONE) && (!w_full || w_ready);
    assign reject  = (w_rise & ~w_win) | ((w_full && !w_ready) ? w_win : 3'b000);
    assign nickel    = w_ready && (w_head == NICKEL);
    assign dime      = w_ready && (w_head == DIME);
    assign quarter   = w_ready && (w_head == QUARTER);
    assign pending   = r_count;
    assign fifo_full = w_full;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= w_code;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_cool  <= 1'b0;
        end else begin
            r_cool <= w_ready;
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_ready)
                r_rd <= r_rd + 1'b1;
            if (w_push && !w_ready)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_ready)
                r_count <= r_count - 1'b1;
        end
    end
endmodule
